// File: rtl/can_acf_pkg.sv
// Shared constants and FSM state type for the CAN acceptance filter.
package can_acf_pkg;

  localparam int DEF_NUM_FILTERS = 4;
  localparam int DEF_MSG_WIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } acf_state_e;

endpackage

// File: rtl/can_acf_entry.sv
// One acceptance filter entry: ID/mask register pair, write gate and compare.
module can_acf_entry
  import can_acf_pkg::*;
#(
  parameter int MSG_WIDTH = DEF_MSG_WIDTH
) (
  input  logic                 i_sys_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr_hit,
  input  logic                 i_uaf,
  input  logic [MSG_WIDTH-1:0] i_wr_afir,
  input  logic [MSG_WIDTH-1:0] i_wr_afmr,
  input  logic [MSG_WIDTH-1:0] i_cmp_msg,
  output logic                 o_match
);

  logic [MSG_WIDTH-1:0] afir_q, afir_d;
  logic [MSG_WIDTH-1:0] afmr_q, afmr_d;

  // Load new ID/mask only while the entry is disabled; otherwise hold.
  always_comb begin
    afir_d = afir_q;
    afmr_d = afmr_q;
    if (i_wr_hit && !i_uaf) begin
      afir_d = i_wr_afir;
      afmr_d = i_wr_afmr;
    end else begin
      afir_d = afir_q;
      afmr_d = afmr_q;
    end
  end

  // Entry register pair, cleared by reset.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      afir_q <= {MSG_WIDTH{1'b0}};
      afmr_q <= {MSG_WIDTH{1'b0}};
    end else begin
      afir_q <= afir_d;
      afmr_q <= afmr_d;
    end
  end

  // Masked compare; a mask bit of 1 means that bit must equal the ID.
  assign o_match = i_uaf && (((i_cmp_msg ^ afir_q) & afmr_q) == {MSG_WIDTH{1'b0}});

endmodule

// File: rtl/can_acf_multi_filter.sv
// Multi-entry CAN acceptance filter scanning entries one per cycle, lowest index wins.
module can_acf_multi_filter
  import can_acf_pkg::*;
#(
  parameter  int NUM_FILTERS = DEF_NUM_FILTERS,
  parameter  int MSG_WIDTH   = DEF_MSG_WIDTH,
  localparam int IDX_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                   i_sys_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_FILTERS-1:0] i_uaf,
  input  logic                   i_wr_en,
  input  logic [IDX_W-1:0]       i_wr_sel,
  input  logic [MSG_WIDTH-1:0]   i_wr_afir,
  input  logic [MSG_WIDTH-1:0]   i_wr_afmr,
  input  logic                   i_rx_valid,
  input  logic [MSG_WIDTH-1:0]   i_rx_message,
  output logic                   o_rx_ready,
  output logic [NUM_FILTERS-1:0] o_acfbsy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic [IDX_W-1:0]       o_match_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  acf_state_e             state_q, state_d;
  logic [NUM_FILTERS-1:0] hit_q, hit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pass_q, pass_d;
  logic [IDX_W-1:0]       midx_q, midx_d;
  logic [NUM_FILTERS-1:0] match_vec_s;
  logic                   cur_hit_s;

  // The compare runs on the offered message with the live enables; the result
  // vector is frozen at acceptance, so later enable changes or entry rewrites
  // cannot disturb a decision already in flight.
  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_entry
    can_acf_entry #(.MSG_WIDTH(MSG_WIDTH)) u_entry (
      .i_sys_clk (i_sys_clk),
      .i_reset_n (i_reset_n),
      .i_wr_hit  (i_wr_en && (i_wr_sel == IDX_W'(k))),
      .i_uaf     (i_uaf[k]),
      .i_wr_afir (i_wr_afir),
      .i_wr_afmr (i_wr_afmr),
      .i_cmp_msg (i_rx_message),
      .o_match   (match_vec_s[k])
    );
  end

  // Select the frozen compare result of the entry under the scan pointer.
  always_comb begin
    cur_hit_s = 1'b0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      cur_hit_s = cur_hit_s | (hit_q[k] & (idx_q == IDX_W'(k)));
    end
  end

  // Next-state and decision logic for the IDLE/SCAN/DONE sequence.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    pass_d  = 1'b0;
    midx_d  = {IDX_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          hit_d = match_vec_s;
          idx_d = {IDX_W{1'b0}};
          if (i_uaf == {NUM_FILTERS{1'b0}}) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cur_hit_s) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
          midx_d  = idx_q;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, snapshot and decision registers.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      hit_q   <= {NUM_FILTERS{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      pass_q  <= 1'b0;
      midx_q  <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      midx_q  <= midx_d;
    end
  end

  assign o_rx_ready  = (state_q == ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = pass_q;
  assign o_match_idx = midx_q;
  assign o_acfbsy    = ~i_uaf;

endmodule

// File: tb/tb_can_acf_multi_filter.sv
// Scoreboard bench for can_acf_multi_filter with a behavioural filter model.
module tb_can_acf_multi_filter;

  localparam int NF = 4;
  localparam int MW = 32;
  localparam int IW = 2;

  typedef struct {
    logic       pass;
    logic [1:0] idx;
    int         lat;
    int         cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] uaf = 4'b0000;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_sel = 2'd0;
  logic [MW-1:0] wr_afir = 32'd0;
  logic [MW-1:0] wr_afmr = 32'd0;
  logic          rx_valid = 1'b0;
  logic [MW-1:0] rx_msg = 32'd0;
  logic          o_rx_ready;
  logic [NF-1:0] o_acfbsy;
  logic          o_done;
  logic          o_pass;
  logic [IW-1:0] o_match_idx;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [MW-1:0] m_afir [NF];
  logic [MW-1:0] m_afmr [NF];
  exp_t          exp_q [$];

  can_acf_multi_filter #(.NUM_FILTERS(NF), .MSG_WIDTH(MW)) dut (
    .i_sys_clk    (clk),
    .i_reset_n    (rst_n),
    .i_uaf        (uaf),
    .i_wr_en      (wr_en),
    .i_wr_sel     (wr_sel),
    .i_wr_afir    (wr_afir),
    .i_wr_afmr    (wr_afmr),
    .i_rx_valid   (rx_valid),
    .i_rx_message (rx_msg),
    .o_rx_ready   (o_rx_ready),
    .o_acfbsy     (o_acfbsy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_match_idx  (o_match_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    else n_pass++;
  endtask

  // Reference: filters are independent; the lowest enabled entry whose masked
  // bits agree wins, and scanning costs one cycle per entry index.
  function automatic exp_t predict(input logic [MW-1:0] msg, input logic [NF-1:0] u);
    exp_t r;
    r.pass = 1'b0;
    r.idx  = 2'd0;
    r.lat  = NF + 1;
    r.cyc  = 0;
    if (u == 4'b0000) begin
      r.pass = 1'b1;
      r.lat  = 1;
    end else begin
      for (int k = NF - 1; k >= 0; k--) begin
        if (u[k] && (((msg ^ m_afir[k]) & m_afmr[k]) == 32'd0)) begin
          r.pass = 1'b1;
          r.idx  = 2'(k);
          r.lat  = k + 2;
        end
      end
    end
    return r;
  endfunction

  // Monitor: pops the oldest expectation whenever a decision is presented.
  exp_t          mon_e;
  logic [NF-1:0] mon_nb;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_nb = ~uaf;
      check("acfbsy", 32'(o_acfbsy), 32'(mon_nb));
      if (o_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(o_done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pass", 32'(o_pass), 32'(mon_e.pass));
          check("match_idx", 32'(o_match_idx), 32'(mon_e.idx));
          check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic wr(input int sel, input logic [MW-1:0] a, input logic [MW-1:0] m);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 2'(sel); wr_afir = a; wr_afmr = m;
    if (sel < NF && !uaf[sel]) begin
      m_afir[sel] = a;
      m_afmr[sel] = m;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Offer one message; returns at the negedge just after the accepting edge.
  task automatic send(input logic [MW-1:0] msg);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!o_rx_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 32'(o_rx_ready), 32'd1);
    e = predict(msg, uaf);
    e.cyc = cyc + e.lat;
    exp_q.push_back(e);
    rx_valid = 1'b1; rx_msg = msg;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !o_rx_ready) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [MW-1:0] msg;
    int            k;
    for (int i = 0; i < NF; i++) begin
      m_afir[i] = 32'd0;
      m_afmr[i] = 32'd0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(o_rx_ready), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_pass", 32'(o_pass), 32'd0);
    check("rst_idx", 32'(o_match_idx), 32'd0);
    check("rst_acfbsy", 32'(o_acfbsy), 32'hF);
    #2 rst_n = 1'b1;

    // No filters enabled: accept everything after one cycle.
    uaf = 4'b0000;
    send(32'h1234_5678);
    wait_idle();

    // Entry 2 masked match and mismatch.
    wr(2, 32'h0000_0100, 32'hFFFF_FF00);
    uaf = 4'b0100;
    send(32'h0000_01AB);
    wait_idle();
    send(32'h0000_02AB);
    wait_idle();

    // Entries 1 and 3 both match: lowest wins; a second offer mid-scan is dropped.
    uaf = 4'b0000;
    wr(1, 32'h0000_0A00, 32'hFFFF_FF00);
    wr(3, 32'h0000_0A00, 32'hFFFF_FF00);
    uaf = 4'b1010;
    send(32'h0000_0A55);
    rx_valid = 1'b1; rx_msg = 32'h0000_0A55;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle();

    // Writes to an enabled entry are ignored.
    uaf = 4'b0000;
    wr(0, 32'h0000_0055, 32'h0000_00FF);
    uaf = 4'b0001;
    wr(0, 32'h0000_0066, 32'h0000_00FF);
    send(32'h0000_0055);
    wait_idle();
    send(32'h0000_0066);
    wait_idle();

    // Enable changes and rewrites during a scan do not alter the decision.
    uaf = 4'b1000;
    send(32'h0000_0A00);
    uaf = 4'b0000;
    wr_en = 1'b1; wr_sel = 2'd3; wr_afir = 32'h0000_BEEF; wr_afmr = 32'hFFFF_FFFF;
    m_afir[3] = 32'h0000_BEEF; m_afmr[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    wr_en = 1'b0;
    uaf = 4'b1000;
    wait_idle();
    send(32'h0000_0A00);
    wait_idle();

    // Reset in the middle of a scan: no decision, registers cleared.
    uaf = 4'b0000;
    wr(0, 32'h0000_DEAD, 32'hFFFF_FFFF);
    uaf = 4'b1001;
    send(32'h0000_1111);
    #2 rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NF; i++) begin
      m_afir[i] = 32'd0;
      m_afmr[i] = 32'd0;
    end
    @(negedge clk);
    check("midrst_ready", 32'(o_rx_ready), 32'd1);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_pass", 32'(o_pass), 32'd0);
    #2 rst_n = 1'b1;
    uaf = 4'b0001;
    send(32'hFFFF_0000);
    wait_idle();

    // Randomized traffic with occasional disturbance during the scan.
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(0, 2)) begin
        uaf = 4'($urandom);
        wr(int'($urandom_range(0, NF - 1)), $urandom, $urandom | (($urandom % 2 == 0) ? 32'd0 : 32'hFFFF_0000));
      end
      uaf = 4'($urandom);
      k = int'($urandom_range(0, NF - 1));
      if ($urandom_range(0, 2) != 0) msg = (m_afir[k] & m_afmr[k]) | ($urandom & ~m_afmr[k]);
      else msg = $urandom;
      send(msg);
      if ($urandom_range(0, 2) == 0) begin
        uaf = 4'($urandom);
        k = int'($urandom_range(0, NF - 1));
        wr_en = 1'b1; wr_sel = 2'(k); wr_afir = $urandom; wr_afmr = $urandom;
        if (!uaf[k]) begin
          m_afir[k] = wr_afir;
          m_afmr[k] = wr_afmr;
        end
        @(negedge clk);
        wr_en = 1'b0;
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_acf_multi_filter.md
CAN_ACF_MULTI_FILTER -- requirements
Module: can_acf_multi_filter

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 4, meaning the number of ID/mask filter entries (legal range 1..16).
REQ-002 SHALL have parameter MSG_WIDTH, default 32, meaning the width of the compared message word, ID register and mask register.
REQ-003 SHALL have derived localparam IDX_W = max(1, clog2(NUM_FILTERS)), meaning the filter index width.
REQ-004 Clock and reset: one clock and an asynchronous, active-low reset, as the ports below.
REQ-005 i_sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-006 i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_uaf  input  NUM_FILTERS  per-filter "use acceptance filter" enable; 0 = entry disabled and writable.
REQ-008 i_wr_en  input  1  one-cycle write strobe for the entry registers.
REQ-009 i_wr_sel  input  IDX_W  index of the entry to write.
REQ-010 i_wr_afir  input  MSG_WIDTH  ID value to write.
REQ-011 i_wr_afmr  input  MSG_WIDTH  mask value to write; 1 = bit compared.
REQ-012 i_rx_valid  input  1  a received message is offered.
REQ-013 i_rx_message  input  MSG_WIDTH  received message word.
REQ-014 o_rx_ready  output  1  block can accept a message.
REQ-015 o_acfbsy  output  NUM_FILTERS  per-entry busy flag, equal to the inverted i_uaf bit.
REQ-016 o_done  output  1  one-cycle pulse when a filter decision is valid.
REQ-017 o_pass  output  1  decision: message accepted; valid only while o_done=1.
REQ-018 o_match_idx  output  IDX_W  lowest-index matching entry; valid only while o_done=1 and o_pass=1.

Function
REQ-019 Entry k SHALL store i_wr_afir/i_wr_afmr when i_wr_en=1, i_wr_sel=k and i_uaf[k]=0; writes to enabled or out-of-range entries are ignored.
REQ-020 Entry k SHALL match when i_uaf[k]=1 and ((msg XOR afir_k) AND afmr_k) = 0.
REQ-021 FSM states: IDLE, SCAN, DONE.
REQ-022 IDLE: o_rx_ready=1; on i_rx_valid=1, capture the message and snapshot i_uaf; go to SCAN with scan index 0, or go to DONE if the snapshot is all zero.
REQ-023 SCAN: evaluate one entry per cycle in ascending index order against the captured message and snapshot; disabled entries are skipped in the same cycle.
REQ-024 SCAN exit: go to DONE on the first match (early exit) or after evaluating entry NUM_FILTERS-1.
REQ-025 DONE: o_done=1 for exactly one cycle, then return to IDLE.
REQ-026 Decision: o_pass=1 if a match was found or the snapshot was all zero (no filters enabled = accept all); otherwise o_pass=0.
REQ-027 Latency: from i_rx_valid accepted to o_done is (m+2) cycles for a first match at index m; NUM_FILTERS+1 cycles for no match; 1 cycle for an all-zero snapshot.
REQ-028 o_rx_ready=0 in SCAN and DONE; i_rx_valid in those states is ignored (no queuing).
REQ-029 Changes to i_uaf or entry writes during SCAN SHALL NOT affect the in-flight decision (snapshot rule); entry writes still take effect per REQ-019.
REQ-030 When no match is found, o_match_idx SHALL read 0.

Reset
REQ-031 Reset SHALL force state IDLE, all afir/afmr registers to 0, and the captured message, snapshot and scan index to 0.
REQ-032 Output reset values: o_rx_ready=1, o_done=0, o_pass=0, o_match_idx=0; o_acfbsy follows i_uaf combinationally.
REQ-033 Reset asserted mid-SCAN SHALL abort the decision with no o_done pulse.

Structure
REQ-034 Package can_acf_pkg SHALL hold the FSM state typedef and the default NUM_FILTERS/MSG_WIDTH constants.
REQ-035 One sub-module, can_acf_entry, SHALL implement a single entry: register pair, write qualification and match compare; it is instantiated NUM_FILTERS times.

Verification
REQ-036 Bench SHALL cover these directed scenarios:
- All i_uaf=0, rx 0x1234_5678 -> o_done one cycle later, o_pass=1.
- Entry2 afir=0x0000_0100, afmr=0xFFFF_FF00, uaf=4'b0100, rx 0x0000_01AB -> o_pass=1, o_match_idx=2, o_done at cycle 4.
- Same setup, rx 0x0000_02AB -> o_pass=0 after 5 cycles.
- Entries 1 and 3 both match -> o_match_idx=1 (early exit); second i_rx_valid during SCAN is ignored.
- Write entry0 while uaf[0]=1 -> registers unchanged; i_uaf toggled mid-SCAN -> decision per snapshot.
- Reset pulsed in SCAN -> no o_done, o_rx_ready=1, registers read 0.
